// File: rtl/mips_perf_cnt_pkg.sv
// Shared definitions for the MIPS performance counter slave:
// FSM encoding, register offsets, CTRL bit positions and byte-merge helper.
package mips_perf_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_ACK  = 2'd2,
    ST_RD_DATA = 2'd3
  } state_e;

  localparam logic [7:0] OFS_CTRL = 8'h00;
  localparam logic [7:0] OFS_OVF  = 8'h04;
  localparam logic [7:0] OFS_CNT0 = 8'h10;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_perf_cnt_cell.sv
// One 32-bit event counter: clear beats load beats increment, 1-cycle update.
// o_wrap flags an increment that rolls 0xFFFF_FFFF over to 0 on this edge.
module mips_perf_cnt_cell
  import mips_perf_cnt_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inc,
  input  logic        i_clr,
  input  logic        i_ld,
  input  logic [3:0]  i_strb,
  input  logic [31:0] i_dat,
  output logic [31:0] o_cnt,
  output logic        o_wrap
);

  logic [31:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= merge_bytes(r_cnt, i_dat, i_strb);
    end else if (i_inc) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = i_inc & ~i_ld & ~i_clr & (&r_cnt);

endmodule

// File: rtl/mips_perf_cnt_slave.sv
// Memory-mapped bank of NUM_CNT event counters; write ack 1 cycle, read data 2 cycles after request.
// Read data is held until Read_data_Ack; new requests are only taken in IDLE.
module mips_perf_cnt_slave
  import mips_perf_cnt_pkg::*;
#(
  parameter int   NUM_CNT = 8,
  parameter logic RST_EN  = 1'b1
) (
  input  logic               mips_cpu_clk,
  input  logic               mips_cpu_reset_n,
  input  logic [NUM_CNT-1:0] evt,
  input  logic [31:0]        Address,
  input  logic               MemWrite,
  input  logic               MemRead,
  input  logic [31:0]        Write_data,
  input  logic [3:0]         Write_strb,
  output logic               Mem_Req_Ack,
  output logic [31:0]        Read_data,
  output logic               Read_data_Valid,
  input  logic               Read_data_Ack
);

  state_e              r_state;
  logic                r_ack;
  logic                r_vld;
  logic [31:0]         r_rdat;
  logic [7:0]          r_ofs;
  logic [31:0]         r_wdat;
  logic [3:0]          r_strb;
  logic                r_en;
  logic [NUM_CNT-1:0]  r_ovf;

  logic                w_commit;
  logic                w_ctrl_hit;
  logic                w_ovf_hit;
  logic                w_cnt_hit;
  logic [5:0]          w_idx;
  logic                w_clr_all;
  logic                w_ovf_wr;
  logic [NUM_CNT-1:0]  w_ld;
  logic [NUM_CNT-1:0]  w_inc;
  logic [NUM_CNT-1:0]  w_wrap;
  logic [NUM_CNT-1:0]  w_ovf_nxt;
  logic [31:0]         w_cnt [NUM_CNT];
  logic [31:0]         w_rd;
  logic                w_unused;

  assign w_unused = ^Address[31:8];

  // Decode works on the offset latched at request time, so it is stable for the whole transaction.
  assign w_commit   = (r_state == ST_WR);
  assign w_ctrl_hit = (r_ofs == OFS_CTRL);
  assign w_ovf_hit  = (r_ofs == OFS_OVF);
  assign w_idx      = r_ofs[7:2] - OFS_CNT0[7:2];
  assign w_cnt_hit  = (r_ofs[1:0] == 2'b00) && (r_ofs >= OFS_CNT0) && (w_idx < 6'(NUM_CNT));
  assign w_clr_all  = w_commit & w_ctrl_hit & r_strb[0] & r_wdat[CTRL_CLR_BIT];
  assign w_ovf_wr   = w_commit & w_ovf_hit & r_strb[0];

  always_comb begin
    w_ld  = '0;
    w_inc = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      w_ld[i]  = w_commit & w_cnt_hit & (w_idx == 6'(i));
      w_inc[i] = r_en & evt[i];
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
    mips_perf_cnt_cell u_cell (
      .i_clk   (mips_cpu_clk),
      .i_rst_n (mips_cpu_reset_n),
      .i_inc   (w_inc[g]),
      .i_clr   (w_clr_all),
      .i_ld    (w_ld[g]),
      .i_strb  (r_strb),
      .i_dat   (r_wdat),
      .o_cnt   (w_cnt[g]),
      .o_wrap  (w_wrap[g])
    );
  end

  // A wrap on the same edge as a W1C keeps the bit set; only byte 0 of OVF is writable.
  always_comb begin
    w_ovf_nxt = r_ovf;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (w_wrap[i]) begin
        w_ovf_nxt[i] = 1'b1;
      end else if (w_ovf_wr && (i < 8) && r_wdat[i]) begin
        w_ovf_nxt[i] = 1'b0;
      end
    end
    if (w_clr_all) w_ovf_nxt = '0;
  end

  always_comb begin
    w_rd = '0;
    if (w_ctrl_hit) begin
      w_rd[CTRL_EN_BIT] = r_en;
    end else if (w_ovf_hit) begin
      w_rd[NUM_CNT-1:0] = r_ovf;
    end else if (w_cnt_hit) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_idx == 6'(i)) w_rd = w_cnt[i];
      end
    end
  end

  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      r_en  <= RST_EN;
      r_ovf <= '0;
    end else begin
      if (w_commit && w_ctrl_hit && r_strb[0]) r_en <= r_wdat[CTRL_EN_BIT];
      r_ovf <= w_ovf_nxt;
    end
  end

  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_vld   <= 1'b0;
      r_rdat  <= '0;
      r_ofs   <= '0;
      r_wdat  <= '0;
      r_strb  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MemWrite) begin
            r_state <= ST_WR;
            r_ack   <= 1'b1;
            r_ofs   <= Address[7:0];
            r_wdat  <= Write_data;
            r_strb  <= Write_strb;
          end else if (MemRead) begin
            r_state <= ST_RD_ACK;
            r_ack   <= 1'b1;
            r_ofs   <= Address[7:0];
          end
        end
        ST_WR: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_RD_ACK: begin
          r_ack   <= 1'b0;
          r_rdat  <= w_rd;
          r_vld   <= 1'b1;
          r_state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (Read_data_Ack) begin
            r_vld   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_vld   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Mem_Req_Ack     = r_ack;
  assign Read_data       = r_rdat;
  assign Read_data_Valid = r_vld;

endmodule

// File: tb/tb_mips_perf_cnt_slave.sv
// Directed-vector bench for mips_perf_cnt_slave with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mips_perf_cnt_slave;

  localparam int NUM = 8;

  logic            clk;
  logic            rst_n;
  logic [NUM-1:0]  evt;
  logic [31:0]     Address;
  logic            MemWrite;
  logic            MemRead;
  logic [31:0]     Write_data;
  logic [3:0]      Write_strb;
  logic            Mem_Req_Ack;
  logic [31:0]     Read_data;
  logic            Read_data_Valid;
  logic            Read_data_Ack;

  int n_vec = 0;
  int n_bad = 0;

  mips_perf_cnt_slave #(.NUM_CNT(NUM), .RST_EN(1'b1)) dut (
    .mips_cpu_clk     (clk),
    .mips_cpu_reset_n (rst_n),
    .evt              (evt),
    .Address          (Address),
    .MemWrite         (MemWrite),
    .MemRead          (MemRead),
    .Write_data       (Write_data),
    .Write_strb       (Write_strb),
    .Mem_Req_Ack      (Mem_Req_Ack),
    .Read_data        (Read_data),
    .Read_data_Valid  (Read_data_Valid),
    .Read_data_Ack    (Read_data_Ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Mem_Req_Ack && n < 8);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [NUM-1:0] ev_commit);
    int n;
    @(negedge clk);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    wait_ack(n);
    check("wr_ack_lat", 32'(n), 32'd1);
    MemWrite = 1'b0;
    evt = ev_commit;
    @(negedge clk);
    evt = '0;
    check("wr_ack_drop", {31'd0, Mem_Req_Ack}, 32'd0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    int m;
    @(negedge clk);
    Address = a; MemRead = 1'b1;
    wait_ack(n);
    check("rd_ack_lat", 32'(n), 32'd1);
    MemRead = 1'b0;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!Read_data_Valid && m < 8);
    check("rd_vld_lat", 32'(m), 32'd1);
    d = Read_data;
    Read_data_Ack = 1'b1;
    @(negedge clk);
    Read_data_Ack = 1'b0;
    check("rd_vld_drop", {31'd0, Read_data_Valid}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic pulse_evt(input logic [NUM-1:0] mask, input int cycles);
    @(negedge clk);
    evt = mask;
    repeat (cycles) @(negedge clk);
    evt = '0;
  endtask

  initial begin
    int n;
    logic seen;

    rst_n = 1'b0; evt = '0; Address = '0; MemWrite = 1'b0; MemRead = 1'b0;
    Write_data = '0; Write_strb = '0; Read_data_Ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'd0, Mem_Req_Ack}, 32'd0);
    check("rst_vld", {31'd0, Read_data_Valid}, 32'd0);
    check("rst_rdata", Read_data, 32'd0);
    rst_n = 1'b1;

    // Ten enabled event cycles on counter 0
    pulse_evt(8'h01, 10);
    rd_chk("cnt0_10", 32'h10, 32'd10);
    rd_chk("ctrl_rst", 32'h00, 32'd1);

    // Wrap of counter 1 and OVF write-1-to-clear
    bus_write(32'h14, 32'hFFFF_FFFE, 4'hF, '0);
    pulse_evt(8'h02, 3);
    rd_chk("cnt1_wrap", 32'h14, 32'd1);
    rd_chk("ovf_set", 32'h04, 32'h0000_0002);
    bus_write(32'h04, 32'h0000_0002, 4'h1, '0);
    rd_chk("ovf_w1c", 32'h04, 32'd0);

    // Simultaneous write and read: write wins, no read data
    @(negedge clk);
    Address = 32'h10; Write_data = 32'h55; Write_strb = 4'hF;
    MemWrite = 1'b1; MemRead = 1'b1;
    wait_ack(n);
    check("both_ack_lat", 32'(n), 32'd1);
    MemWrite = 1'b0; MemRead = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (Read_data_Valid) seen = 1'b1;
    end
    check("both_no_vld", {31'd0, seen}, 32'd0);
    rd_chk("both_wr_val", 32'h10, 32'h55);

    // Byte-lane write beats a same-edge increment
    bus_write(32'h18, 32'h11, 4'hF, '0);
    bus_write(32'h18, 32'h0000_AB00, 4'h2, 8'h04);
    rd_chk("cnt2_merge", 32'h18, 32'h0000_AB11);

    // OVF set on the same edge as its W1C keeps the bit
    bus_write(32'h20, 32'hFFFF_FFFF, 4'hF, '0);
    bus_write(32'h04, 32'h0000_0010, 4'h1, 8'h10);
    rd_chk("ovf_set_wins", 32'h04, 32'h0000_0010);
    rd_chk("cnt4_wrapped", 32'h20, 32'd0);

    // Last counter and unmapped offsets
    bus_write(32'h2C, 32'h1234_5678, 4'hF, '0);
    rd_chk("cnt7", 32'h2C, 32'h1234_5678);
    rd_chk("unmap_08", 32'h08, 32'd0);
    bus_write(32'h30, 32'hDEAD_BEEF, 4'hF, '0);
    rd_chk("unmap_30", 32'h30, 32'd0);
    rd_chk("unmap_12", 32'h12, 32'd0);

    // CTRL only honours byte 0
    bus_write(32'h00, 32'h0000_0000, 4'hE, '0);
    rd_chk("ctrl_strb_hi", 32'h00, 32'd1);

    // Disable stops counting
    bus_write(32'h00, 32'h0, 4'hF, '0);
    rd_chk("ctrl_dis", 32'h00, 32'd0);
    pulse_evt(8'hFF, 5);
    rd_chk("dis_cnt0", 32'h10, 32'h55);
    rd_chk("dis_cnt2", 32'h18, 32'h0000_AB11);
    rd_chk("dis_ovf", 32'h04, 32'h0000_0010);

    // Enable + clear_all, then counting resumes
    bus_write(32'h00, 32'h3, 4'h1, '0);
    rd_chk("ctrl_en_clr", 32'h00, 32'd1);
    rd_chk("clr_ovf", 32'h04, 32'd0);
    rd_chk("clr_cnt0", 32'h10, 32'd0);
    rd_chk("clr_cnt7", 32'h2C, 32'd0);
    pulse_evt(8'h08, 4);
    rd_chk("resume_cnt3", 32'h1C, 32'd4);
    bus_write(32'h00, 32'h3, 4'h1, 8'hFF);
    rd_chk("clr_vs_inc3", 32'h1C, 32'd0);
    rd_chk("clr_vs_inc0", 32'h10, 32'd0);

    // Reset while read data is waiting for acceptance
    bus_write(32'h24, 32'h99, 4'hF, '0);
    bus_write(32'h00, 32'h0, 4'h1, '0);
    @(negedge clk);
    Address = 32'h24; MemRead = 1'b1;
    wait_ack(n);
    check("rst_rd_ack_lat", 32'(n), 32'd1);
    MemRead = 1'b0;
    @(negedge clk);
    check("rst_rd_vld", {31'd0, Read_data_Valid}, 32'd1);
    check("rst_rd_dat", Read_data, 32'h99);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_vld", {31'd0, Read_data_Valid}, 32'd0);
    check("rst_async_dat", Read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_cnt5", 32'h24, 32'd0);
    rd_chk("post_rst_ctrl", 32'h00, 32'd1);
    pulse_evt(8'h01, 2);
    rd_chk("post_rst_cnt0", 32'h10, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
